// File: rtl/booth_pkg.sv
// Shared definitions for the Booth product accumulator: default widths,
// FSM state encoding and saturation bound helpers.
package booth_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } acc_state_t;

    // Bounds of a w-bit signed value, returned in the low w bits.
    function automatic logic [63:0] SAT_MAX(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] SAT_MIN(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed add of a PROD_W operand into an ACC_W accumulator,
// with overflow detection and optional clamping to the signed range.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              sat_en_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX(ACC_W));
    localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN(ACC_W));

    logic [ACC_W:0] sum_wide;

    // One guard bit: the two top bits disagree exactly when the true sum
    // does not fit in ACC_W signed bits.
    assign sum_wide = {acc_i[ACC_W-1], acc_i}
                    + {{(ACC_W + 1 - PROD_W){prod_i[PROD_W-1]}}, prod_i};
    assign ovf_o    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    always_comb begin
        sum_o = sum_wide[ACC_W-1:0];
        if (sat_en_i && ovf_o) begin
            sum_o = sum_wide[ACC_W] ? SAT_LO : SAT_HI;
        end
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates a programmed number of signed products with a valid/ready
// front end, optional saturation and a sticky per-job overflow flag.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              sat_en,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res,
    output logic              res_ovf,
    output logic              busy
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [LEN_W-1:0] cnt_inc;

    booth_sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_add (
        .acc_i    (acc_q),
        .prod_i   (prod),
        .sat_en_i (sat_q),
        .sum_o    (add_sum),
        .ovf_o    (add_ovf)
    );

    assign cnt_inc = cnt_q + LEN_W'(1);

    // Handshake outputs come straight from the state register.
    assign prod_ready = (state_q == ACCUM);
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign res        = acc_q;
    assign res_ovf    = ovf_q;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no
        // path through the case can infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sat_d   = sat_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    sat_d   = sat_en;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_ovf;
                    if (cnt_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, and reset is
    // sampled on the clock edge rather than asynchronously.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Self-checking bench: two accumulators (16- and 10-bit) share one stimulus
// stream; directed vectors, a mid-job reset and random jobs against a model.
module tb_booth_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] len = '0;
    logic       sat_en = 1'b0;
    logic       prod_valid = 1'b0;
    logic [7:0] prod = '0;
    logic       res_ready = 1'b0;

    logic        pr16, rv16, ov16, bz16;
    logic        pr10, rv10, ov10, bz10;
    logic [15:0] r16;
    logic [9:0]  r10;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] job_prods [15];

    typedef struct {
        int              n;
        bit              sat;
        int              vmode;
        int              stall;
        bit              glitch;
        logic [0:14][7:0] p;
        logic [15:0]     e16;
        bit              o16;
        logic [9:0]      e10;
        bit              o10;
    } vec_t;

    vec_t vt [9];

    always #5 clk = ~clk;

    booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .sat_en(sat_en),
        .prod_valid(prod_valid), .prod_ready(pr16), .prod(prod),
        .res_valid(rv16), .res_ready(res_ready), .res(r16), .res_ovf(ov16), .busy(bz16)
    );

    booth_product_accumulator #(.PROD_W(8), .ACC_W(10), .LEN_W(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .sat_en(sat_en),
        .prod_valid(prod_valid), .prod_ready(pr10), .prod(prod),
        .res_valid(rv10), .res_ready(res_ready), .res(r10), .res_ovf(ov10), .busy(bz10)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: integer sum with range test after every term.
    function automatic void model(input int n, input bit sat, input int w,
                                  output logic [31:0] r, output bit o);
        longint mx, mn, acc, span;
        span = longint'(1) <<< w;
        mx   = (longint'(1) <<< (w - 1)) - 1;
        mn   = -(longint'(1) <<< (w - 1));
        acc  = 0;
        o    = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc = acc + longint'($signed(job_prods[i]));
            if (acc > mx || acc < mn) begin
                o = 1'b1;
                if (sat) acc = (acc > mx) ? mx : mn;
                else if (acc > mx) acc = acc - span;
                else acc = acc + span;
            end
        end
        r = 32'(acc & (span - 1));
    endfunction

    task automatic run_job(input int n, input bit sat, input int vmode, input int stall,
                           input bit glitch,
                           output logic [15:0] g16, output logic og16,
                           output logic [9:0] g10, output logic og10);
        int fed, cyc, last;
        bit seen_ready, stable, v;
        fed = 0; cyc = 0; last = -1; seen_ready = 0; stable = 1;
        start = 1'b1; len = 4'(n); sat_en = sat;
        prod_valid = 1'b1; prod = 8'h7F;
        @(negedge clk);
        start = glitch; len = 4'd7; sat_en = ~sat;
        check("busy_after_start", bz16, 1);
        while (!rv16 && cyc < 400) begin
            if (pr16) begin
                seen_ready = 1;
                case (vmode)
                    0:       v = 1;
                    1:       v = (cyc % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                prod_valid = v;
                prod = (fed < n) ? job_prods[fed] : 8'h7F;
                if (v) begin
                    fed++;
                    last = cyc;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("res_valid_seen", rv16, 1);
        check("xfer_count", fed, n);
        check("latency", cyc, (n == 0) ? 0 : last + 1);
        check("ready_seen", seen_ready, (n != 0));
        check("dut10_res_valid", rv10, rv16);
        g16 = r16; og16 = ov16; g10 = r10; og10 = ov10;
        prod_valid = 1'b1; prod = 8'h7F;
        for (int i = 0; i < stall; i++) begin
            res_ready = 1'b0;
            @(negedge clk);
            if (!rv16 || r16 !== g16 || ov16 !== og16 || r10 !== g10 || ov10 !== og10 || pr16)
                stable = 0;
        end
        check("stall_stable", stable, 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0; start = 1'b0; prod_valid = 1'b0;
        check("idle_after_ack", {rv16, bz16, rv10, bz10}, 0);
    endtask

    initial begin
        logic [15:0] g16;
        logic [9:0]  g10;
        logic        og16, og10;
        logic [31:0] m16, m10;
        bit          mo16, mo10;
        int          n;
        bit          sat;

        vt[0] = '{4, 0, 0, 0, 0, {8'hF4, 8'h0F, 8'h80, 8'h01, {11{8'h00}}}, 16'hFF84, 0, 10'h384, 0};
        vt[1] = '{4, 0, 1, 5, 0, {8'hF4, 8'h0F, 8'h80, 8'h01, {11{8'h00}}}, 16'hFF84, 0, 10'h384, 0};
        vt[2] = '{5, 1, 0, 0, 0, {{5{8'h7F}}, {10{8'h00}}}, 16'h027B, 0, 10'h1FF, 1};
        vt[3] = '{5, 0, 0, 1, 0, {{5{8'h7F}}, {10{8'h00}}}, 16'h027B, 0, 10'h27B, 1};
        vt[4] = '{0, 0, 0, 2, 0, {15{8'h55}}, 16'h0000, 0, 10'h000, 0};
        vt[5] = '{15, 1, 0, 0, 0, {15{8'h80}}, 16'hF880, 0, 10'h200, 1};
        vt[6] = '{15, 0, 1, 0, 0, {15{8'h80}}, 16'hF880, 0, 10'h080, 1};
        vt[7] = '{6, 1, 0, 0, 0, {{5{8'h7F}}, 8'h80, {9{8'h00}}}, 16'h01FB, 0, 10'h17F, 1};
        vt[8] = '{3, 0, 0, 2, 1, {8'h10, 8'h20, 8'h30, {12{8'h00}}}, 16'h0060, 0, 10'h060, 0};

        repeat (3) @(negedge clk);
        check("reset_outputs16", {pr16, rv16, ov16, bz16}, 0);
        check("reset_outputs10", {pr10, rv10, ov10, bz10}, 0);
        check("reset_res", {r16, r10}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            for (int k = 0; k < 15; k++) job_prods[k] = vt[i].p[k];
            run_job(vt[i].n, vt[i].sat, vt[i].vmode, vt[i].stall, vt[i].glitch,
                    g16, og16, g10, og10);
            check($sformatf("vec%0d_res16", i), g16, vt[i].e16);
            check($sformatf("vec%0d_ovf16", i), og16, vt[i].o16);
            check($sformatf("vec%0d_res10", i), g10, vt[i].e10);
            check($sformatf("vec%0d_ovf10", i), og10, vt[i].o10);
        end

        // Reset after two of four products aborts the job.
        start = 1'b1; len = 4'd4; sat_en = 1'b0;
        @(negedge clk);
        start = 1'b0; prod_valid = 1'b1; prod = 8'h11;
        @(negedge clk);
        prod = 8'h22;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midjob_reset_idle", {bz16, rv16, pr16, bz10, rv10, pr10}, 0);
        check("midjob_reset_res", {r16, 6'b0, ov16}, 0);
        rst_n = 1'b1; prod_valid = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {bz16, pr16}, 0);
        job_prods[0] = 8'h05;
        run_job(1, 0, 0, 0, 0, g16, og16, g10, og10);
        check("post_reset_res16", g16, 16'h0005);
        check("post_reset_res10", g10, 10'h005);

        for (int j = 0; j < 24; j++) begin
            n   = $urandom_range(0, 15);
            sat = 1'($urandom_range(0, 1));
            for (int k = 0; k < 15; k++) job_prods[k] = 8'($urandom);
            model(n, sat, 16, m16, mo16);
            model(n, sat, 10, m10, mo10);
            run_job(n, sat, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    g16, og16, g10, og10);
            check($sformatf("rand%0d_res16", j), g16, m16);
            check($sformatf("rand%0d_ovf16", j), og16, mo16);
            check($sformatf("rand%0d_res10", j), g10, m10);
            check($sformatf("rand%0d_ovf10", j), og10, mo10);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
